// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: single-port frame-buffer RAM port shared by the arbiter (master) and the BRAM (slave)
interface fb_arbiter_if #(
    parameter int c_nb_addr = 15,
    parameter int c_nb_data = 12
);
    logic                 we;
    logic [c_nb_addr-1:0] addr;
    logic [c_nb_data-1:0] wdata;
    logic [c_nb_data-1:0] rdata;
    modport master (output we, addr, wdata, input rdata);
    modport slave (input we, addr, wdata, output rdata);
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: VGA reads own their slot, camera writes queue in a FIFO and drain into the free cycles
module fb_arbiter #(
    parameter int c_img_cols   = 160,
    parameter int c_img_rows   = 120,
    parameter int c_nb_addr    = 15,
    parameter int c_nb_data    = 12,
    parameter int c_fifo_depth = 4
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 vga_new_pxl_i,
    input  logic                 vga_visible_i,
    input  logic [9:0]           vga_col_i,
    input  logic [9:0]           vga_row_i,
    input  logic                 cam_we_i,
    input  logic [c_nb_addr-1:0] cam_addr_i,
    input  logic [c_nb_data-1:0] cam_data_i,
    output logic                 cam_ovf_o,
    output logic [c_nb_data-1:0] pxl_rgb_o,
    fb_arbiter_if.master         mem
);
    localparam int PW = $clog2(c_fifo_depth);
    localparam int CW = PW + 1;

    logic                 slot_q, rd_pend_q, blank_pend_q, cam_ovf_q;
    logic [c_nb_data-1:0] pxl_rgb_q;
    logic [PW-1:0]        wr_q, rd_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [c_nb_addr-1:0] fifo_addr_q [c_fifo_depth];
    logic [c_nb_data-1:0] fifo_data_q [c_fifo_depth];
    logic                 in_img, rd_slot, pop, push;
    logic [c_nb_addr-1:0] rd_addr;

    assign in_img  = vga_visible_i && vga_col_i < 10'(c_img_cols) && vga_row_i < 10'(c_img_rows);
    assign rd_slot = slot_q && in_img;
    assign rd_addr = c_nb_addr'(32'(vga_row_i) * c_img_cols + 32'(vga_col_i));
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign pop     = !rd_slot && cnt_q != '0;
    assign push    = cam_we_i && (cnt_q < CW'(c_fifo_depth) || pop);
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);

    assign mem.we    = pop;
    assign mem.addr  = rd_slot ? rd_addr : pop ? fifo_addr_q[rd_q] : '0;
    assign mem.wdata = pop ? fifo_data_q[rd_q] : '0;
    assign cam_ovf_o = cam_ovf_q;
    assign pxl_rgb_o = pxl_rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
            blank_pend_q <= 1'b0;
            cam_ovf_q    <= 1'b0;
            pxl_rgb_q    <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
        end else begin
            slot_q       <= vga_new_pxl_i;
            rd_pend_q    <= rd_slot;
            blank_pend_q <= slot_q && !in_img;
            cnt_q        <= cnt_d;
            if (push) wr_q <= wr_q + PW'(1);
            if (pop) rd_q <= rd_q + PW'(1);
            if (cam_we_i && !push) cam_ovf_q <= 1'b1;
            if (rd_pend_q) pxl_rgb_q <= mem.rdata;
            else if (blank_pend_q) pxl_rgb_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_q] <= cam_addr_i;
            fifo_data_q[wr_q] <= cam_data_i;
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: scoreboard bench for fb_arbiter with a behavioural one-cycle-latency RAM
module tb_fb_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        vga_new_pxl = 1'b0, vga_visible = 1'b0, cam_we = 1'b0;
    logic [9:0]  vga_col = '0, vga_row = '0;
    logic [14:0] cam_addr = '0;
    logic [11:0] cam_data = '0;
    logic        cam_ovf;
    logic [11:0] pxl_rgb;
    logic        pl_en = 1'b0;
    logic [14:0] pl_addr = '0;
    logic [11:0] pl_data = '0;
    logic [11:0] ram [19200];
    logic [26:0] wq [$];
    logic [11:0] pq [$];
    logic [26:0] wexp;
    int          cmps = 0, errs = 0;

    fb_arbiter_if #(.c_nb_addr(15), .c_nb_data(12)) mem ();

    fb_arbiter dut (
        .rst(rst), .clk(clk),
        .vga_new_pxl_i(vga_new_pxl), .vga_visible_i(vga_visible),
        .vga_col_i(vga_col), .vga_row_i(vga_row),
        .cam_we_i(cam_we), .cam_addr_i(cam_addr), .cam_data_i(cam_data),
        .cam_ovf_o(cam_ovf), .pxl_rgb_o(pxl_rgb), .mem(mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem.we) ram[mem.addr] <= mem.wdata;
        mem.rdata <= ram[mem.addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic test_reset;
        preload(15'd0, 12'h5A5);
        vga_new_pxl = 1'b1;
        tick;
        vga_new_pxl = 1'b0; vga_visible = 1'b1; vga_col = 10'd0; vga_row = 10'd0;
        tick; tick;
        @(negedge clk);
        cmps++; if (pxl_rgb !== 12'h5A5) begin errs++; $display("FAIL rst_pre_pxl got %h exp 5a5", pxl_rgb); end
        tick;
        for (int i = 0; i < 3; i++) begin
            cam_we = 1'b1; cam_addr = 15'(100 + i); cam_data = 12'(12'h200 + i);
            wq.push_back({cam_addr, cam_data});
            tick;
        end
        rst = 1'b1; cam_addr = 15'd103; cam_data = 12'h203;
        @(negedge clk);
        cmps++; if (wq.size() !== 1) begin errs++; $display("FAIL rst_pending got %0d exp 1", wq.size()); end
        cmps++; if (mem.we !== 1'b0) begin errs++; $display("FAIL rst_we got %b exp 0", mem.we); end
        cmps++; if (mem.addr !== 15'd0) begin errs++; $display("FAIL rst_addr got %0d exp 0", mem.addr); end
        cmps++; if (mem.wdata !== 12'h0) begin errs++; $display("FAIL rst_wdata got %h exp 0", mem.wdata); end
        cmps++; if (pxl_rgb !== 12'h0) begin errs++; $display("FAIL rst_pxl got %h exp 0", pxl_rgb); end
        cmps++; if (cam_ovf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b exp 0", cam_ovf); end
        wq.delete();
        tick; tick;
        rst = 1'b0; cam_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cmps++; if (mem.we !== 1'b0) begin errs++; $display("FAIL rst_idle_we cycle %0d got %b exp 0", i, mem.we); end
            tick;
        end
    endtask

    task automatic test_read_addr;
        preload(15'd162, 12'hABC);
        vga_new_pxl = 1'b1;
        tick;
        vga_new_pxl = 1'b0; vga_col = 10'd2; vga_row = 10'd1; vga_visible = 1'b1;
        @(negedge clk);
        cmps++; if (mem.we !== 1'b0) begin errs++; $display("FAIL rd_we got %b exp 0", mem.we); end
        cmps++; if (mem.addr !== 15'd162) begin errs++; $display("FAIL rd_addr got %0d exp 162", mem.addr); end
        tick;
        @(negedge clk);
        cmps++; if (pxl_rgb !== 12'h0) begin errs++; $display("FAIL rd_latency got %h exp 0", pxl_rgb); end
        tick;
        @(negedge clk);
        cmps++; if (pxl_rgb !== 12'hABC) begin errs++; $display("FAIL rd_pxl got %h exp abc", pxl_rgb); end
        tick;
    endtask

    task automatic test_outside;
        vga_new_pxl = 1'b1; cam_we = 1'b1; cam_addr = 15'd50; cam_data = 12'h0F0;
        wq.push_back({cam_addr, cam_data});
        tick;
        vga_new_pxl = 1'b0; cam_we = 1'b0; vga_col = 10'd200; vga_row = 10'd10;
        @(negedge clk);
        cmps++; if (mem.we !== 1'b1) begin errs++; $display("FAIL out_we got %b exp 1", mem.we); end
        cmps++; if (mem.addr !== 15'd50) begin errs++; $display("FAIL out_addr got %0d exp 50", mem.addr); end
        tick; tick;
        @(negedge clk);
        cmps++; if (pxl_rgb !== 12'h0) begin errs++; $display("FAIL out_pxl got %h exp 0", pxl_rgb); end
        tick;
        cmps++; if (wq.size() !== 0) begin errs++; $display("FAIL out_drain got %0d exp 0", wq.size()); end
    endtask

    task automatic test_collision;
        vga_new_pxl = 1'b1; cam_we = 1'b1; cam_addr = 15'd5; cam_data = 12'h123;
        wq.push_back({cam_addr, cam_data});
        tick;
        vga_new_pxl = 1'b0; cam_we = 1'b0; vga_col = 10'd3; vga_row = 10'd1;
        @(negedge clk);
        cmps++; if (mem.we !== 1'b0) begin errs++; $display("FAIL col_rd_we got %b exp 0", mem.we); end
        cmps++; if (mem.addr !== 15'd163) begin errs++; $display("FAIL col_rd_addr got %0d exp 163", mem.addr); end
        tick;
        @(negedge clk);
        cmps++; if (mem.we !== 1'b1) begin errs++; $display("FAIL col_wr_we got %b exp 1", mem.we); end
        cmps++; if (mem.addr !== 15'd5) begin errs++; $display("FAIL col_wr_addr got %0d exp 5", mem.addr); end
        cmps++; if (mem.wdata !== 12'h123) begin errs++; $display("FAIL col_wr_data got %h exp 123", mem.wdata); end
        tick; tick;
        cmps++; if (wq.size() !== 0) begin errs++; $display("FAIL col_drain got %0d exp 0", wq.size()); end
    endtask

    task automatic test_back_to_back;
        logic [11:0] e;
        for (int k = 0; k < 4; k++) preload(15'(320 + k), 12'(12'h700 + k * 17));
        for (int k = 0; k < 5; k++) begin
            vga_new_pxl = 1'b1; cam_we = 1'b0;
            @(negedge clk);
            if (k > 0) begin
                e = pq.pop_front();
                cmps++; if (pxl_rgb !== e) begin errs++; $display("FAIL b2b_pxl %0d got %h exp %h", k - 1, pxl_rgb, e); end
            end
            if (k == 4) break;
            tick;
            vga_new_pxl = 1'b0; vga_col = 10'(k); vga_row = 10'd2; vga_visible = 1'b1;
            cam_we = 1'b1; cam_addr = 15'(1000 + k); cam_data = 12'(k);
            wq.push_back({cam_addr, cam_data});
            pq.push_back(12'(12'h700 + k * 17));
            tick;
            cam_we = 1'b0;
            tick; tick;
        end
        tick;
        vga_new_pxl = 1'b0;
        repeat (4) tick;
        cmps++; if (wq.size() !== 0) begin errs++; $display("FAIL b2b_drain got %0d exp 0", wq.size()); end
    endtask

    task automatic test_overflow;
        int   mcnt, seen;
        logic movf, rd, mpop, macc;
        logic acc [24];
        for (int i = 0; i < 24; i++) preload(15'(i), 12'hFFF);
        mcnt = 0; movf = 1'b0; seen = -1;
        for (int c = 0; c < 24; c++) begin
            vga_new_pxl = (c % 4 == 0);
            if (c % 4 == 1) begin vga_col = 10'(10 + c / 4); vga_row = 10'd0; vga_visible = 1'b1; end
            rd = (c % 4 == 1);
            mpop = !rd && mcnt > 0;
            macc = mcnt < 4 || mpop;
            cam_we = 1'b1; cam_addr = 15'(c); cam_data = 12'(12'h300 + c);
            if (macc) wq.push_back({cam_addr, cam_data});
            acc[c] = macc;
            @(negedge clk);
            cmps++; if (cam_ovf !== movf) begin errs++; $display("FAIL ovf_flag cycle %0d got %b exp %b", c, cam_ovf, movf); end
            if (cam_ovf === 1'b1 && seen < 0) seen = c;
            mcnt = mcnt + int'(macc) - int'(mpop);
            if (!macc) movf = 1'b1;
            tick;
        end
        cam_we = 1'b0; vga_new_pxl = 1'b0;
        repeat (8) tick;
        cmps++; if (seen !== 14) begin errs++; $display("FAIL ovf_first got %0d exp 14", seen); end
        cmps++; if (cam_ovf !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", cam_ovf); end
        cmps++; if (wq.size() !== 0) begin errs++; $display("FAIL ovf_drain got %0d exp 0", wq.size()); end
        for (int i = 0; i < 24; i++) begin
            cmps++;
            if (ram[i] !== (acc[i] ? 12'(12'h300 + i) : 12'hFFF)) begin
                errs++; $display("FAIL ovf_ram[%0d] got %h exp %h", i, ram[i], acc[i] ? 12'(12'h300 + i) : 12'hFFF);
            end
        end
    endtask

    task automatic test_ordering;
        vga_new_pxl = 1'b1; vga_visible = 1'b0; cam_we = 1'b1; cam_addr = 15'd7; cam_data = 12'h111;
        wq.push_back({cam_addr, cam_data});
        tick;
        vga_new_pxl = 1'b0; cam_data = 12'h222;
        wq.push_back({cam_addr, cam_data});
        tick;
        cam_we = 1'b0;
        repeat (4) tick;
        cmps++; if (ram[7] !== 12'h222) begin errs++; $display("FAIL ord_ram7 got %h exp 222", ram[7]); end
        cmps++; if (wq.size() !== 0) begin errs++; $display("FAIL ord_drain got %0d exp 0", wq.size()); end
        cmps++; if (cam_ovf !== 1'b1) begin errs++; $display("FAIL ord_ovf_sticky got %b exp 1", cam_ovf); end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && mem.we) begin
                    cmps++;
                    if (wq.size() == 0) begin
                        errs++; $display("FAIL wr_scoreboard got addr=%0d data=%h exp no write", mem.addr, mem.wdata);
                    end else begin
                        wexp = wq.pop_front();
                        if ({mem.addr, mem.wdata} !== wexp) begin
                            errs++; $display("FAIL wr_scoreboard got addr=%0d data=%h exp addr=%0d data=%h",
                                             mem.addr, mem.wdata, wexp[26:12], wexp[11:0]);
                        end
                    end
                end
            end
        join_none
        repeat (3) tick;
        rst = 1'b0;
        tick;
        test_reset;
        test_read_addr;
        test_outside;
        test_collision;
        test_back_to_back;
        test_overflow;
        test_ordering;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Shares one single-port frame-buffer RAM between two requesters: the VGA reader, driven by the `vga_sync` timing outputs, and the camera capture writer. The VGA read always wins its slot; camera writes are queued in a small FIFO and drained into the free cycles between reads. The block sits between the camera capture logic, the frame-buffer BRAM and the VGA colour outputs in the 100 MHz `clk` domain.

## Interface
- `c_img_cols`, 160: stored image width in pixels
- `c_img_rows`, 120: stored image height in lines
- `c_nb_addr`, 15: frame-buffer address width (must hold `c_img_cols*c_img_rows-1`)
- `c_nb_data`, 12: pixel width (RGB444)
- `c_fifo_depth`, 4: camera write FIFO depth (power of 2)
- `rst`  in  1  reset, asynchronous, active-high
- `clk`  in  1  clock, 100 MHz
- `vga_new_pxl`  in  1  one-cycle pixel strobe from `vga_sync`; col/row change the cycle after
- `vga_visible`  in  1  from `vga_sync`
- `vga_col`  in  10  from `vga_sync`
- `vga_row`  in  10  from `vga_sync`
- `cam_we`  in  1  camera write request, single cycle
- `cam_addr`  in  c_nb_addr  camera write address
- `cam_data`  in  c_nb_data  camera write data
- `cam_ovf`  out  1  sticky: a camera write was dropped
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  c_nb_addr  RAM address
- `mem_wdata`  out  c_nb_data  RAM write data
- `mem_rdata`  in  c_nb_data  RAM read data, valid 1 clk after the address
- `pxl_rgb`  out  c_nb_data  pixel colour to the VGA pins

## Operation
- **Reset values:**
  - `cam_ovf` = 0, `pxl_rgb` = 0, FIFO empty.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `slot_d` = 0, `rd_pend` = 0.
- **Slot tracking:** `slot_d` is `vga_new_pxl` delayed 1 clk.
- **Read slot:** the cycle with `slot_d` = 1 and `in_img` = 1.
  - `in_img` = `vga_visible` && `vga_col` < `c_img_cols` && `vga_row` < `c_img_rows`.
- **Write slot:** every other cycle. A read slot is never shared.
- **Read slot actions:**
  - `mem_we` = 0.
  - `mem_addr` = `vga_row*c_img_cols + vga_col`, truncated to `c_nb_addr` bits.
  - Set `rd_pend`.
- **Write slot actions:**
  - If the FIFO is non-empty: pop the head, `mem_we` = 1, `mem_addr`/`mem_wdata` = head entry.
  - Otherwise `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Memory port drive:** `mem_we`, `mem_addr` and `mem_wdata` are combinational from the slot decision and the FIFO head.
- **Read return:** the cycle after a read slot (`rd_pend` = 1), register `mem_rdata` into `pxl_rgb` and clear `rd_pend`.
- **Blanking output:** the cycle after `slot_d` = 1 with `in_img` = 0, register 0 into `pxl_rgb`. Out-of-image and blanking pixels are black.
- **FIFO:** `c_fifo_depth` entries of {addr, data}.
  - Push on `cam_we`. A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped: the FIFO is unchanged and `cam_ovf` is set.
- **`cam_ovf`:** cleared only by `rst`.
- **Empty FIFO:** pushing and popping in the same cycle is not bypassed. The new entry is written at the earliest in the next write slot.
- **Ordering:** FIFO order is preserved. Two writes to the same address land in arrival order.

## Timing
- Cycle T: `vga_new_pxl` = 1.
- T+1: new col/row. This is the read slot if `in_img` = 1.
- T+2: `mem_rdata` valid. `pxl_rgb` is loaded at the end of T+2.
- T+3 through the next pixel's T+2: `pxl_rgb` holds the value. Fixed latency is 2 clk after the col/row change, identical for every pixel.
- **Write-slot budget:** at least 3 write slots per 4-clk pixel period; 4 during blanking or out-of-image pixels.
- **Camera write latency:** a camera write reaches the RAM 1 clk after the push at minimum. It can be delayed 1 more clk if that cycle is a read slot.
- **Reset mid-operation:**
  - Queued writes are discarded and an in-flight read is abandoned.
  - `pxl_rgb` returns to 0.
  - Normal operation resumes on the first `vga_new_pxl` after `rst` falls.

## Test plan
- **Reset:** assert `rst` with `cam_we` = 1 and the FIFO partly full.
  - Required: all outputs at their reset values.
  - Required: no `mem_we` for 8 clk after release while `cam_we` = 0.
- **Read address:** `vga_row` = 1, `vga_col` = 2, `vga_visible` = 1, preload RAM[162] = 0xABC.
  - Required: `mem_addr` = 162 with `mem_we` = 0 at T+1.
  - Required: `pxl_rgb` = 0xABC from T+3.
- **Outside the image:** `vga_col` = 200, `vga_row` = 10.
  - Required: no read issued; `pxl_rgb` = 0 from T+3.
  - Required: a write pushed at T is issued at T+1.
- **Collision:** `cam_we` with addr 5, data 0x123 in cycle T, in-image pixel.
  - Required: T+1 is a read.
  - Required: `mem_we` = 1 with `mem_addr` = 5, `mem_wdata` = 0x123 at T+2.
- **Overflow:** `cam_we` every clk for 24 clk during in-image pixels, sequential addresses 0..23.
  - Required: the FIFO fills by the 4th read slot.
  - Required: `cam_ovf` rises on the first dropped write and stays 1.
  - Required: RAM holds the accepted entries in order.
- **Ordering:** two writes to addr 7 (0x111, then 0x222) during blanking.
  - Required: RAM[7] = 0x222.
